// File: rtl/exe_mem_pipe.sv
// Execute-to-memory pipeline register with a two-slot skid buffer, bubble-gated
// write controls, synchronous flush and stall/retire performance counters.
module exe_mem_pipe #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             wregin,
    input  logic             m2regin,
    input  logic             wmemin,
    input  logic [4:0]       RdRtin,
    input  logic [31:0]      aluresult,
    input  logic [31:0]      qb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wregout,
    output logic             m2regout,
    output logic             wmemout,
    output logic [4:0]       RdRtout,
    output logic [31:0]      aluresultout,
    output logic [31:0]      qbout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] retire_count
);

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] qb;
    } entry_t;

    if (DEPTH != 2) begin : g_depth_check
        $error("exe_mem_pipe: DEPTH must be 2 (head + skid)");
    end

    entry_t           in_entry;
    entry_t           head_q, head_d, skid_q, skid_d;
    logic             head_valid_q, head_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             push, pop;

    assign in_entry = {wregin, m2regin, wmemin, RdRtin, aluresult, qb};
    assign in_ready = ~skid_valid_q;
    assign push     = in_valid & in_ready;
    assign pop      = head_valid_q & out_ready;

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!head_valid_q) begin
            if (push) begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
            end
        end else if (!skid_valid_q) begin
            if (push && pop) begin
                head_d = in_entry;
            end else if (push) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else if (pop) begin
                head_valid_d = 1'b0;
            end
        end else if (pop) begin
            head_d       = skid_q;
            skid_valid_d = 1'b0;
        end
    end

    // Counters ignore flush: a retire coincident with flush still counts.
    always_comb begin
        stall_d  = stall_q;
        retire_d = retire_q;
        if (head_valid_q && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (pop) begin
            retire_d = retire_q + 1'b1;
        end
    end

    // NOTE: payload registers are reset too, so stale-payload outputs read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_q      <= '0;
            retire_q     <= '0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_q      <= stall_d;
            retire_q     <= retire_d;
        end
    end

    assign out_valid    = head_valid_q;
    assign wregout      = head_q.wreg  & head_valid_q;
    assign m2regout     = head_q.m2reg & head_valid_q;
    assign wmemout      = head_q.wmem  & head_valid_q;
    assign RdRtout      = head_q.rd;
    assign aluresultout = head_q.alu;
    assign qbout        = head_q.qb;
    assign stall_count  = stall_q;
    assign retire_count = retire_q;

endmodule
